pcs_fixed_pattern_checker: RTL and testbench
============================================

Name: pcs_fixed_pattern_checker

Overview:
Receive-side checker for the fixed-pattern PCS data-block loopback. It watches the 66-bit blocks presented on the serdes RX interface and hunts for the repeating 6-entry pattern sequence driven by the TX stimulus. It then locks to that sequence and counts per-block mismatches. It sits between the serdes RX port and the eth_phy_10g RX path. It reports lock status and error counters for on-chip self-test, so the loopback check no longer relies on bench-only comparison.

Parameters:
DATA_WIDTH, 64, block payload width; only 64 supported.
HDR_WIDTH, 2, sync header width.
LOCK_COUNT, 4, consecutive in-sequence blocks required to declare lock (1..15).
UNLOCK_COUNT, 3, consecutive mismatching blocks that drop lock (1..15).
ERR_WIDTH, 16, width of error and block counters.

Ports:
rx_clk  input  1  block clock.
rx_rst_n  input  1  reset, asynchronous assert, active-low.
serdes_rx_data  input  64  received block payload.
serdes_rx_hdr  input  2  received sync header.
serdes_rx_valid  input  1  block qualifier; blocks with valid low are ignored.
cfg_clear  input  1  synchronous clear of both counters and the sticky flag.
pattern_lock  output  1  checker is locked to the sequence.
pattern_error  output  1  one-cycle pulse on each errored block while locked.
error_count  output  ERR_WIDTH  errored blocks counted while locked; saturating.
block_count  output  ERR_WIDTH  blocks checked while locked; saturating.
error_sticky  output  1  set by any error while locked; cleared only by cfg_clear or reset.

Behaviour:
- Pattern table, index 0..5:
  - FFFFFFFFFFFFFFFF
  - 0000000000000000
  - 5555555555555555
  - AAAAAAAAAAAAAAAA
  - FEFEFEFEFEFEFEFE
  - 0707070707070707
- Expected header is 2'b01 (data block). A block matches only if both header and payload match.
- Reset: all outputs 0; state HUNT; expected index 0; run/miss counters 0.
- Registered compare. pattern_error, counters, and pattern_lock update one cycle after the block is sampled (latency 1).
- HUNT state:
  - A valid block matching table[k] for any k loads expected=(k+1) mod 6, sets run=1, and goes to VERIFY. If LOCK_COUNT==1, it goes directly to LOCKED.
  - Non-matching blocks stay in HUNT.
  - Counters do not change.
- VERIFY state:
  - Valid block equal to table[expected]: run++, expected advances. When run reaches LOCK_COUNT, go to LOCKED and assert pattern_lock.
  - Mismatch: return to HUNT. That same block is re-evaluated as a HUNT candidate, so it may restart VERIFY with run=1.
- LOCKED state:
  - Every valid block increments block_count.
  - Mismatch: pulse pattern_error, increment error_count, set error_sticky, miss++.
  - Match: miss clears.
  - expected advances on every valid block, match or not, so a single corrupted block does not slip alignment.
  - When miss reaches UNLOCK_COUNT: go to HUNT, deassert pattern_lock in that update cycle, clear miss and run.
- serdes_rx_valid low: no state, index, or counter change. pattern_error stays 0.
- Index wrap: 5 -> 0.
- Counters saturate at all-ones and never wrap.
- cfg_clear:
  - Zeroes error_count, block_count, and error_sticky next cycle. It does not affect lock or state.
  - If cfg_clear coincides with a counted block, clear wins and the count is 0.
- Reset mid-lock: asynchronous return to the reset state above.

Decomposition:
- Package pcs_pattern_pkg holds:
  - PATTERN_NUM=6
  - the pattern table constants
  - SYNC_DATA=2'b01
  - the state encoding (HUNT, VERIFY, LOCKED)
- One sub-module, pcs_pattern_match. It is purely combinational: given data, hdr, and expected index, it outputs hit_any, hit_index[2:0], and hit_expected. The top module holds the FSM and counters.

Test Plan:
- Clean sequence: reset, then present patterns 0..5 repeating with hdr=01 and valid=1. Required: pattern_lock rises 1 cycle after the 4th block. error_count=0. block_count equals blocks since lock.
- Offset start: begin the stream at index 3 (AAAA...). Required: lock after 4 blocks, expected index tracks correctly, no errors.
- Single corruption: once locked, replace one block with 1234567812345678. Required: one pattern_error pulse, error_count=1, error_sticky=1, lock held, next block counted as a match.
- Loss of lock: 3 consecutive bad blocks (hdr=10). Required: error_count=3, pattern_lock=0 after the 3rd. Resuming the clean stream relocks after 4 blocks.
- Valid gaps plus clear: insert valid=0 cycles of garbage data while locked. Required: no counter change. Then pulse cfg_clear. Required: counters=0, sticky=0, lock unchanged.
- Saturation and reset: with ERR_WIDTH=4, inject 20 errors with UNLOCK_COUNT=15 and good blocks interleaved. Required: error_count holds at 15. Then assert rx_rst_n=0 mid-stream. Required: all outputs 0 immediately.

Source files
------------

// File: rtl/pcs_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcs_pattern_pkg
// Purpose  : Shared definitions for the fixed-pattern PCS loopback checker:
//            the 6-entry pattern table, the data-block sync header and the
//            checker state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pcs_pattern_pkg;

  localparam int PATTERN_NUM = 6;

  localparam logic [63:0] PATTERN_0 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PATTERN_1 = 64'h0000_0000_0000_0000;
  localparam logic [63:0] PATTERN_2 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PATTERN_3 = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] PATTERN_4 = 64'hFEFE_FEFE_FEFE_FEFE;
  localparam logic [63:0] PATTERN_5 = 64'h0707_0707_0707_0707;

  localparam logic [1:0] SYNC_DATA = 2'b01;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Table lookup; indices 6 and 7 are never produced by the checker.
  function automatic logic [63:0] pattern_at(input logic [2:0] idx);
    logic [63:0] pat;
    case (idx)
      3'd0:    pat = PATTERN_0;
      3'd1:    pat = PATTERN_1;
      3'd2:    pat = PATTERN_2;
      3'd3:    pat = PATTERN_3;
      3'd4:    pat = PATTERN_4;
      3'd5:    pat = PATTERN_5;
      default: pat = 64'h0;
    endcase
    return pat;
  endfunction

  // Sequence index advance with wrap from the last entry back to 0.
  function automatic logic [2:0] next_index(input logic [2:0] idx);
    return (idx == 3'(PATTERN_NUM - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_pattern_match.sv
`default_nettype none
// ============================================================================
// Module   : pcs_pattern_match
// Purpose  : Combinational block comparator. Checks one received block
//            against every pattern table entry and against the entry the
//            checker currently expects. A hit requires the data sync header.
// Ports    : i_data         - received 64-bit payload
//            i_hdr          - received 2-bit sync header
//            i_exp_idx      - table index the checker expects next
//            o_hit_any      - block equals some table entry
//            o_hit_index    - index of the matching entry (valid with hit_any)
//            o_hit_expected - block equals the expected entry
// Revision : 1.0 - initial release
// ============================================================================
module pcs_pattern_match
  import pcs_pattern_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [1:0]  i_hdr,
  input  logic [2:0]  i_exp_idx,
  output logic        o_hit_any,
  output logic [2:0]  o_hit_index,
  output logic        o_hit_expected
);

  logic                   w_hdr_ok;
  logic [PATTERN_NUM-1:0] w_hit_vec;

  assign w_hdr_ok = (i_hdr == SYNC_DATA);

  generate
    for (genvar gi = 0; gi < PATTERN_NUM; gi++) begin : g_cmp
      assign w_hit_vec[gi] = w_hdr_ok && (i_data == pattern_at(3'(gi)));
    end
  endgenerate

  // Table entries are distinct, so at most one bit of w_hit_vec is set.
  always_comb begin
    o_hit_index = 3'd0;
    for (int i = PATTERN_NUM - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        o_hit_index = 3'(i);
      end
    end
  end

  assign o_hit_any      = |w_hit_vec;
  assign o_hit_expected = w_hdr_ok && (i_data == pattern_at(i_exp_idx));

endmodule
`default_nettype wire

// File: rtl/pcs_fixed_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module   : pcs_fixed_pattern_checker
// Purpose  : Receive-side checker for the fixed-pattern PCS loopback. Hunts
//            for the repeating 6-entry pattern sequence, locks after
//            LOCK_COUNT in-sequence blocks, then counts checked and errored
//            blocks until UNLOCK_COUNT consecutive misses drop lock.
// Ports    : rx_clk          - block clock
//            rx_rst_n        - asynchronous active-low reset
//            serdes_rx_data  - received payload
//            serdes_rx_hdr   - received sync header
//            serdes_rx_valid - block qualifier
//            cfg_clear       - synchronous clear of counters and sticky flag
//            pattern_lock    - locked to the sequence
//            pattern_error   - one-cycle pulse per errored block while locked
//            error_count     - saturating errored-block count
//            block_count     - saturating checked-block count
//            error_sticky    - any error seen while locked
// Revision : 1.0 - initial release
// ============================================================================
module pcs_fixed_pattern_checker
  import pcs_pattern_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int HDR_WIDTH    = 2,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic [DATA_WIDTH-1:0] serdes_rx_data,
  input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  input  logic                  serdes_rx_valid,
  input  logic                  cfg_clear,
  output logic                  pattern_lock,
  output logic                  pattern_error,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic [ERR_WIDTH-1:0]  block_count,
  output logic                  error_sticky
);

  localparam logic [3:0] c_LOCK   = 4'(LOCK_COUNT);
  localparam logic [3:0] c_UNLOCK = 4'(UNLOCK_COUNT);

  state_t               r_state;
  logic [2:0]           r_exp_idx;
  logic [3:0]           r_run;
  logic [3:0]           r_miss;
  logic                 r_lock;
  logic                 r_perr;
  logic [ERR_WIDTH-1:0] r_err_cnt;
  logic [ERR_WIDTH-1:0] r_blk_cnt;
  logic                 r_sticky;

  state_t               w_state_nxt;
  logic [2:0]           w_exp_idx_nxt;
  logic [3:0]           w_run_nxt;
  logic [3:0]           w_miss_nxt;
  logic                 w_perr_nxt;
  logic [ERR_WIDTH-1:0] w_err_cnt_nxt;
  logic [ERR_WIDTH-1:0] w_blk_cnt_nxt;
  logic                 w_sticky_nxt;

  logic                 w_hit_any;
  logic [2:0]           w_hit_index;
  logic                 w_hit_expected;

  pcs_pattern_match u_match (
    .i_data         (serdes_rx_data),
    .i_hdr          (serdes_rx_hdr),
    .i_exp_idx      (r_exp_idx),
    .o_hit_any      (w_hit_any),
    .o_hit_index    (w_hit_index),
    .o_hit_expected (w_hit_expected)
  );

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state   <= ST_HUNT;
      r_exp_idx <= 3'd0;
      r_run     <= 4'd0;
      r_miss    <= 4'd0;
      r_lock    <= 1'b0;
      r_perr    <= 1'b0;
      r_err_cnt <= '0;
      r_blk_cnt <= '0;
      r_sticky  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_exp_idx <= w_exp_idx_nxt;
      r_run     <= w_run_nxt;
      r_miss    <= w_miss_nxt;
      r_lock    <= (w_state_nxt == ST_LOCKED);
      r_perr    <= w_perr_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_blk_cnt <= w_blk_cnt_nxt;
      r_sticky  <= w_sticky_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_exp_idx_nxt = r_exp_idx;
    w_run_nxt     = r_run;
    w_miss_nxt    = r_miss;
    w_perr_nxt    = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    w_blk_cnt_nxt = r_blk_cnt;
    w_sticky_nxt  = r_sticky;

    if (serdes_rx_valid) begin
      if (r_state == ST_LOCKED) begin
        if (r_blk_cnt != '1) begin
          w_blk_cnt_nxt = r_blk_cnt + ERR_WIDTH'(1);
        end
        // Index advances regardless of match so one bad block cannot slip alignment.
        w_exp_idx_nxt = next_index(r_exp_idx);
        if (w_hit_expected) begin
          w_miss_nxt = 4'd0;
        end else begin
          w_perr_nxt   = 1'b1;
          w_sticky_nxt = 1'b1;
          if (r_err_cnt != '1) begin
            w_err_cnt_nxt = r_err_cnt + ERR_WIDTH'(1);
          end
          if (r_miss + 4'd1 == c_UNLOCK) begin
            w_state_nxt = ST_HUNT;
            w_miss_nxt  = 4'd0;
            w_run_nxt   = 4'd0;
          end else begin
            w_miss_nxt = r_miss + 4'd1;
          end
        end
      end else if ((r_state == ST_VERIFY) && w_hit_expected) begin
        w_exp_idx_nxt = next_index(r_exp_idx);
        w_run_nxt     = r_run + 4'd1;
        if (r_run + 4'd1 == c_LOCK) begin
          w_state_nxt = ST_LOCKED;
          w_miss_nxt  = 4'd0;
        end
      end else if (w_hit_any) begin
        // HUNT candidate; also covers a VERIFY miss being re-evaluated.
        w_exp_idx_nxt = next_index(w_hit_index);
        w_run_nxt     = 4'd1;
        w_miss_nxt    = 4'd0;
        w_state_nxt   = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
      end else begin
        w_state_nxt = ST_HUNT;
        w_run_nxt   = 4'd0;
      end
    end

    // Clear takes priority over a block counted in the same cycle.
    if (cfg_clear) begin
      w_err_cnt_nxt = '0;
      w_blk_cnt_nxt = '0;
      w_sticky_nxt  = 1'b0;
    end
  end

  assign pattern_lock  = r_lock;
  assign pattern_error = r_perr;
  assign error_count   = r_err_cnt;
  assign block_count   = r_blk_cnt;
  assign error_sticky  = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_pcs_fixed_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_fixed_pattern_checker
// Purpose  : Self-checking bench. Two checkers share one stimulus stream:
//            A with default parameters, B with ERR_WIDTH=4, UNLOCK_COUNT=15.
//            Each is compared every cycle with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_fixed_pattern_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data = '0;
  logic [1:0]  hdr = 2'b00;
  logic        valid = 1'b0;
  logic        clr = 1'b0;

  logic        lock_a, perr_a, sticky_a;
  logic [15:0] err_a, blk_a;
  logic        lock_b, perr_b, sticky_b;
  logic [3:0]  err_b, blk_b;

  int n_checks = 0;
  int n_errors = 0;
  int idx = 0;

  logic [63:0] tab [6] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000,
                           64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA,
                           64'hFEFEFEFEFEFEFEFE, 64'h0707070707070707};

  always #5 clk = ~clk;

  pcs_fixed_pattern_checker u_dut_a (
    .rx_clk(clk), .rx_rst_n(rst_n), .serdes_rx_data(data), .serdes_rx_hdr(hdr),
    .serdes_rx_valid(valid), .cfg_clear(clr), .pattern_lock(lock_a),
    .pattern_error(perr_a), .error_count(err_a), .block_count(blk_a),
    .error_sticky(sticky_a)
  );

  pcs_fixed_pattern_checker #(.ERR_WIDTH(4), .UNLOCK_COUNT(15)) u_dut_b (
    .rx_clk(clk), .rx_rst_n(rst_n), .serdes_rx_data(data), .serdes_rx_hdr(hdr),
    .serdes_rx_valid(valid), .cfg_clear(clr), .pattern_lock(lock_b),
    .pattern_error(perr_b), .error_count(err_b), .block_count(blk_b),
    .error_sticky(sticky_b)
  );

  // mode: 0 searching, 1 confirming, 2 locked
  typedef struct {
    int mode; int exp; int run; int miss; int err; int blk;
    bit sticky; bit lock; bit perr;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.mode = 0; m.exp = 0; m.run = 0; m.miss = 0; m.err = 0; m.blk = 0;
    m.sticky = 0; m.lock = 0; m.perr = 0;
    return m;
  endfunction

  function automatic int find_hit(input logic [63:0] d, input logic [1:0] h);
    if (h !== 2'b01) return -1;
    for (int k = 0; k < 6; k++) if (d === tab[k]) return k;
    return -1;
  endfunction

  function automatic model_t model_step(input model_t mi, input int lockc, input int unlockc,
                                        input int maxc, input logic [63:0] d,
                                        input logic [1:0] h, input logic v, input logic c);
    model_t m = mi;
    int k;
    m.perr = 0;
    if (v) begin
      k = find_hit(d, h);
      if (m.mode == 2) begin
        m.blk = (m.blk < maxc) ? m.blk + 1 : maxc;
        if (k != m.exp) begin
          m.perr = 1; m.sticky = 1; m.miss++;
          m.err = (m.err < maxc) ? m.err + 1 : maxc;
        end else m.miss = 0;
        m.exp = (m.exp + 1) % 6;
        if (m.miss == unlockc) begin m.mode = 0; m.miss = 0; m.run = 0; end
      end else if (m.mode == 1 && k == m.exp) begin
        m.run++; m.exp = (m.exp + 1) % 6;
        if (m.run == lockc) begin m.mode = 2; m.miss = 0; end
      end else if (k >= 0) begin
        m.exp = (k + 1) % 6; m.run = 1; m.miss = 0;
        m.mode = (lockc == 1) ? 2 : 1;
      end else begin
        m.mode = 0; m.run = 0;
      end
    end
    if (c) begin m.err = 0; m.blk = 0; m.sticky = 0; end
    m.lock = (m.mode == 2);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    check("a_lock",   32'(lock_a),   32'(ma.lock));
    check("a_perr",   32'(perr_a),   32'(ma.perr));
    check("a_err",    32'(err_a),    32'(ma.err));
    check("a_blk",    32'(blk_a),    32'(ma.blk));
    check("a_sticky", 32'(sticky_a), 32'(ma.sticky));
    check("b_lock",   32'(lock_b),   32'(mb.lock));
    check("b_perr",   32'(perr_b),   32'(mb.perr));
    check("b_err",    32'(err_b),    32'(mb.err));
    check("b_blk",    32'(blk_b),    32'(mb.blk));
    check("b_sticky", 32'(sticky_b), 32'(mb.sticky));
  endtask

  task automatic drive(input logic [63:0] d, input logic [1:0] h, input logic v, input logic c);
    @(negedge clk);
    data = d; hdr = h; valid = v; clr = c;
    @(posedge clk);
    ma = model_step(ma, 4, 3, 65535, d, h, v, c);
    mb = model_step(mb, 4, 15, 15, d, h, v, c);
    #1;
    compare_all();
  endtask

  task automatic send_good();
    drive(tab[idx], 2'b01, 1'b1, 1'b0);
    idx = (idx + 1) % 6;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; clr = 1'b0;
    #1;
    ma = model_reset(); mb = model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] rnd;
    int r;
    ma = model_reset(); mb = model_reset();

    // Reset state
    do_reset();

    // Clean sequence from index 0: lock one cycle after the 4th block
    idx = 0;
    repeat (3) send_good();
    check("clean_lock_early", 32'(lock_a), 32'd0);
    send_good();
    check("clean_lock_4th", 32'(lock_a), 32'd1);
    repeat (10) send_good();
    check("clean_blk", 32'(blk_a), 32'd10);
    check("clean_err", 32'(err_a), 32'd0);

    // Offset start at index 3
    do_reset();
    idx = 3;
    repeat (3) send_good();
    check("offset_lock_early", 32'(lock_a), 32'd0);
    send_good();
    check("offset_lock", 32'(lock_a), 32'd1);
    repeat (8) send_good();
    check("offset_err", 32'(err_a), 32'd0);

    // Single corrupted block
    drive(64'h1234567812345678, 2'b01, 1'b1, 1'b0);
    idx = (idx + 1) % 6;
    check("corrupt_pulse", 32'(perr_a), 32'd1);
    check("corrupt_err", 32'(err_a), 32'd1);
    check("corrupt_sticky", 32'(sticky_a), 32'd1);
    check("corrupt_lock", 32'(lock_a), 32'd1);
    send_good();
    check("corrupt_next_ok", 32'(perr_a), 32'd0);
    repeat (4) send_good();

    // Loss of lock: three bad headers, then relock
    drive('0, 2'b00, 1'b0, 1'b1);
    repeat (3) begin
      drive(tab[idx], 2'b10, 1'b1, 1'b0);
      idx = (idx + 1) % 6;
    end
    check("loss_err", 32'(err_a), 32'd3);
    check("loss_lock", 32'(lock_a), 32'd0);
    check("loss_b_held", 32'(lock_b), 32'd1);
    repeat (3) send_good();
    check("relock_early", 32'(lock_a), 32'd0);
    send_good();
    check("relock", 32'(lock_a), 32'd1);

    // Valid gaps of garbage while locked, then clear
    repeat (5) begin
      rnd = {$urandom, $urandom};
      drive(rnd, 2'($urandom), 1'b0, 1'b0);
    end
    check("gap_blk", 32'(blk_a), 32'(ma.blk));
    check("gap_perr", 32'(perr_a), 32'd0);
    drive(tab[idx], 2'b01, 1'b1, 1'b1);
    idx = (idx + 1) % 6;
    check("clear_err", 32'(err_a), 32'd0);
    check("clear_blk", 32'(blk_a), 32'd0);
    check("clear_sticky", 32'(sticky_b), 32'd0);
    check("clear_lock", 32'(lock_a), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        rnd = {$urandom, $urandom};
        drive(rnd, 2'($urandom), 1'b0, ($urandom_range(0, 49) == 0));
      end else if (r < 27) begin
        rnd = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : tab[$urandom_range(0, 5)];
        drive(rnd, 2'($urandom), 1'b1, ($urandom_range(0, 49) == 0));
        idx = (idx + 1) % 6;
      end else if (r < 29) begin
        idx = $urandom_range(0, 5);
        send_good();
      end else begin
        drive(tab[idx], 2'b01, 1'b1, ($urandom_range(0, 49) == 0));
        idx = (idx + 1) % 6;
      end
    end

    // Saturation on the narrow-counter instance
    repeat (8) send_good();
    repeat (20) begin
      drive(64'h1234567812345678, 2'b01, 1'b1, 1'b0);
      idx = (idx + 1) % 6;
      send_good();
    end
    check("sat_err_b", 32'(err_b), 32'd15);
    check("sat_blk_b", 32'(blk_b), 32'd15);
    check("sat_lock_b", 32'(lock_b), 32'd1);
    check("sat_lock_a", 32'(lock_a), 32'd1);

    // Reset mid-stream: outputs go to zero without a clock edge
    do_reset();
    check("rst_lock", 32'(lock_a), 32'd0);
    check("rst_err_b", 32'(err_b), 32'd0);
    repeat (6) send_good();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
